// File: rtl/data_bus_ram_slave_if.sv
// DataBus: CPU-side data bus between one master and a memory-mapped slave.
// memType uses the MemType_t encoding: BYTE = 3'b000, WORD = 3'b010.
interface DataBus;
    logic [31:0] addr;
    logic        read;
    logic        write;
    logic [2:0]  memType;
    logic [31:0] dataOut;
    logic        ready;
    logic [31:0] dataIn;

    modport master (
        output addr, read, write, memType, dataOut,
        input  ready, dataIn
    );

    modport slave (
        input  addr, read, write, memType, dataOut,
        output ready, dataIn
    );
endinterface

// File: rtl/data_bus_ram_slave.sv
// data_bus_ram_slave: RAM responder on the slave side of DataBus.
// BYTE/WORD accesses, WAIT_STATES extra cycles, 4-phase ready handshake.
// All state changes on the falling edge of clk.
// Optional build macro DATA_BUS_RAM_BYTE_SIGNEXT_EN: BYTE reads sign-extend
// bit 7 into dataIn[31:8] (default build zero-extends).
module data_bus_ram_slave #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input logic   clk,
    input logic   rst,
    DataBus.slave bus
);

    localparam int         AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] MT_BYTE      = 3'b000;
    localparam logic [3:0] LP_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_HOLD
    } state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [2:0]  r_type;
    logic [31:0] r_wdata;
    logic        r_is_write;
    logic [3:0]  r_cnt;
    logic        r_ready;
    logic [31:0] r_rdata;
    logic [31:0] r_mem [DEPTH];

    logic          w_in_range;
    logic          w_is_byte;
    logic [AW-1:0] w_idx;
    logic [4:0]    w_shift;
    logic [31:0]   w_word;
    logic [31:0]   w_lane;
    logic [31:0]   w_rd_fmt;
    logic          w_mem_we;

    assign w_in_range = (r_addr[31:2] < 30'(DEPTH));
    assign w_is_byte  = (r_type == MT_BYTE);
    assign w_idx      = r_addr[AW+1:2];
    assign w_shift    = {r_addr[1:0], 3'b000};
    assign w_word     = w_in_range ? r_mem[w_idx] : '0;
    assign w_lane     = w_word >> w_shift;
    // The access itself happens at the edge leaving DONE; reset at that edge cancels it.
    assign w_mem_we   = !rst && (r_state == S_DONE) && r_is_write && w_in_range;

    // Format read data: full word, or the addressed byte lane extended to 32 bits.
    always_comb begin
        w_rd_fmt = w_word;
        if (w_is_byte) begin
`ifdef DATA_BUS_RAM_BYTE_SIGNEXT_EN
            w_rd_fmt = {{24{w_lane[7]}}, w_lane[7:0]};
`else
            w_rd_fmt = {24'h00_0000, w_lane[7:0]};
`endif
        end
    end

    // Storage write port; contents survive reset.
    always_ff @(negedge clk) begin
        if (w_mem_we) begin
            if (w_is_byte) begin
                r_mem[w_idx][w_shift +: 8] <= r_wdata[7:0];
            end else begin
                r_mem[w_idx] <= r_wdata;
            end
        end
    end

    // Handshake FSM: capture request, count wait states, respond, hold until released.
    always_ff @(negedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b0;
            r_rdata    <= '0;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_type     <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b0;
                    if (bus.read || bus.write) begin
                        r_addr     <= bus.addr;
                        r_type     <= bus.memType;
                        r_wdata    <= bus.dataOut;
                        r_is_write <= bus.write;
                        if (WAIT_STATES > 0) begin
                            r_state <= S_WAIT;
                            r_cnt   <= LP_WAIT_LOAD;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b1;
                    r_rdata <= r_is_write ? '0 : w_rd_fmt;
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    if (!bus.read && !bus.write) begin
                        r_ready <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready  = r_ready;
    assign bus.dataIn = r_rdata;

endmodule

// File: tb/tb_data_bus_ram_slave.sv
// Testbench for data_bus_ram_slave: three instances (WAIT_STATES = 1, 0, 3)
// share one stimulus driver; a selector routes the request to one instance.
module tb_data_bus_ram_slave;

    localparam int         DEPTH   = 1024;
    localparam logic [2:0] MT_BYTE = 3'b000;
    localparam logic [2:0] MT_WORD = 3'b010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int          sel    = 0;
    logic [31:0] t_addr = '0;
    logic [31:0] t_wd   = '0;
    logic [2:0]  t_type = MT_WORD;
    logic        t_rd   = 1'b0;
    logic        t_wr   = 1'b0;

    DataBus bus0 ();
    DataBus bus1 ();
    DataBus bus2 ();

    assign bus0.addr = t_addr;  assign bus0.memType = t_type;  assign bus0.dataOut = t_wd;
    assign bus1.addr = t_addr;  assign bus1.memType = t_type;  assign bus1.dataOut = t_wd;
    assign bus2.addr = t_addr;  assign bus2.memType = t_type;  assign bus2.dataOut = t_wd;
    assign bus0.read = t_rd && (sel == 0);  assign bus0.write = t_wr && (sel == 0);
    assign bus1.read = t_rd && (sel == 1);  assign bus1.write = t_wr && (sel == 1);
    assign bus2.read = t_rd && (sel == 2);  assign bus2.write = t_wr && (sel == 2);

    data_bus_ram_slave #(.DEPTH(DEPTH), .WAIT_STATES(1)) u_ws1 (.clk(clk), .rst(rst), .bus(bus0));
    data_bus_ram_slave #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (.clk(clk), .rst(rst), .bus(bus1));
    data_bus_ram_slave #(.DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (.clk(clk), .rst(rst), .bus(bus2));

    logic        o_ready;
    logic [31:0] o_din;
    always_comb begin
        o_ready = bus2.ready;
        o_din   = bus2.dataIn;
        if (sel == 0) begin
            o_ready = bus0.ready;
            o_din   = bus0.dataIn;
        end else if (sel == 1) begin
            o_ready = bus1.ready;
            o_din   = bus1.dataIn;
        end
    end

    int checks   = 0;
    int failures = 0;

    // Reference memory image per instance (only written words are ever read back).
    logic [31:0] mdl [3][DEPTH];

    function automatic int ws_of(input int d);
        if (d == 0) return 1;
        if (d == 1) return 0;
        return 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one access to the reference image; returns the expected dataIn.
    task automatic model_apply(input int d, input logic [31:0] a, input logic [2:0] t,
                               input logic rd, input logic wr, input logic [31:0] wd,
                               output logic [31:0] exp);
        logic [31:0] w;
        int unsigned sh;
        int unsigned idx;
        exp = 32'h0;
        sh  = 8 * (a % 4);
        idx = a / 4;
        if (wr) begin
            if (a < 4 * DEPTH) begin
                if (t == MT_BYTE) begin
                    w = mdl[d][idx];
                    mdl[d][idx] = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
                end else begin
                    mdl[d][idx] = wd;
                end
            end
        end else if (rd) begin
            if (a < 4 * DEPTH) begin
                w = mdl[d][idx];
                if (t == MT_BYTE) begin
                    exp = (w >> sh) & 32'hFF;
`ifdef DATA_BUS_RAM_BYTE_SIGNEXT_EN
                    if (exp >= 32'h80) exp = exp | 32'hFFFF_FF00;
`endif
                end else begin
                    exp = w;
                end
            end
        end
    endtask

    // One complete handshake: drive, measure latency, check data, optional hold, release.
    task automatic bus_access(input int d, input logic [31:0] a, input logic [2:0] t,
                              input logic rd, input logic wr, input logic [31:0] wd,
                              input int hold, input string tag, output logic [31:0] got);
        logic [31:0] exp;
        int lat;
        model_apply(d, a, t, rd, wr, wd, exp);
        @(posedge clk);
        sel = d; t_addr = a; t_type = t; t_rd = rd; t_wr = wr; t_wd = wd;
        @(negedge clk);
        lat = 0;
        @(posedge clk);
        while (!o_ready && lat < 40) begin
            @(negedge clk);
            lat++;
            @(posedge clk);
        end
        check({tag, " latency"}, 32'(lat), 32'(ws_of(d) + 1));
        got = o_din;
        check({tag, " data"}, got, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            @(posedge clk);
            check({tag, " hold ready"}, 32'(o_ready), 32'd1);
            check({tag, " hold data"}, o_din, got);
        end
        t_rd = 1'b0; t_wr = 1'b0;
        @(negedge clk);
        @(posedge clk);
        check({tag, " release"}, 32'(o_ready), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        logic [2:0]  t;
        int          op;
        logic        seen;

        // Reset: two falling edges with rst high.
        repeat (2) @(negedge clk);
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            sel = d;
            #1;
            check("reset ready", 32'(o_ready), 32'd0);
            check("reset dataIn", o_din, 32'h0);
        end
        rst = 1'b0;

        // Basic word write / read, WAIT_STATES=1.
        bus_access(0, 32'h10, MT_WORD, 1'b0, 1'b1, 32'hDEAD_BEEF, 0, "w10", r);
        check("write completion data", r, 32'h0);
        bus_access(0, 32'h10, MT_WORD, 1'b1, 1'b0, 32'h0, 0, "r10", r);
        check("read 0x10", r, 32'hDEAD_BEEF);

        // Byte lanes.
        bus_access(0, 32'h20, MT_WORD, 1'b0, 1'b1, 32'h1122_3344, 0, "w20", r);
        bus_access(0, 32'h22, MT_BYTE, 1'b0, 1'b1, 32'h0000_00AA, 0, "wb22", r);
        bus_access(0, 32'h20, MT_WORD, 1'b1, 1'b0, 32'h0, 0, "r20", r);
        check("word after byte write", r, 32'h11AA_3344);
        bus_access(0, 32'h23, MT_BYTE, 1'b1, 1'b0, 32'h0, 0, "rb23", r);
        check("byte read lane3", r, 32'h0000_0011);
        bus_access(0, 32'h22, MT_BYTE, 1'b1, 1'b0, 32'h0, 0, "rb22", r);
`ifdef DATA_BUS_RAM_BYTE_SIGNEXT_EN
        check("byte read lane2 sext", r, 32'hFFFF_FFAA);
`else
        check("byte read lane2 zext", r, 32'h0000_00AA);
`endif

        // Held request: ready and dataIn stay put until the master releases.
        bus_access(0, 32'h40, MT_WORD, 1'b0, 1'b1, 32'h1, 0, "w40a", r);
        bus_access(0, 32'h40, MT_WORD, 1'b0, 1'b1, 32'h2, 6, "w40b held", r);
        bus_access(0, 32'h40, MT_WORD, 1'b1, 1'b0, 32'h0, 6, "r40 held", r);
        check("read after held write", r, 32'h2);

        // Out of range and simultaneous read/write.
        bus_access(0, 32'h0, MT_WORD, 1'b0, 1'b1, 32'h0BAD_F00D, 0, "w0", r);
        bus_access(0, 32'h1000, MT_WORD, 1'b1, 1'b0, 32'h0, 0, "r oor", r);
        check("oor read", r, 32'h0);
        bus_access(0, 32'h1000, MT_WORD, 1'b0, 1'b1, 32'hFFFF_FFFF, 0, "w oor", r);
        bus_access(0, 32'h0, MT_WORD, 1'b1, 1'b0, 32'h0, 0, "r0 after oor", r);
        check("word0 after oor write", r, 32'h0BAD_F00D);
        bus_access(0, 32'h0, MT_WORD, 1'b1, 1'b1, 32'h5, 0, "rw0", r);
        check("read+write completion", r, 32'h0);
        bus_access(0, 32'h0, MT_WORD, 1'b1, 1'b0, 32'h0, 0, "r0 after rw", r);
        check("write wins", r, 32'h5);

        // WAIT_STATES=0.
        bus_access(1, 32'h50, MT_WORD, 1'b0, 1'b1, 32'hCAFE_0001, 0, "ws0 w", r);
        bus_access(1, 32'h50, MT_WORD, 1'b1, 1'b0, 32'h0, 0, "ws0 r", r);
        check("ws0 read", r, 32'hCAFE_0001);

        // Reset in the middle of a WAIT_STATES=3 write.
        bus_access(2, 32'h30, MT_WORD, 1'b0, 1'b1, 32'hA5A5_A5A5, 0, "ws3 pre", r);
        @(posedge clk);
        sel = 2; t_addr = 32'h30; t_type = MT_WORD; t_rd = 1'b0; t_wr = 1'b1; t_wd = 32'h1234_5678;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        rst = 1'b0; t_wr = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            @(posedge clk);
            seen = seen | o_ready;
        end
        check("mid-access reset ready", 32'(seen), 32'd0);
        bus_access(2, 32'h30, MT_WORD, 1'b1, 1'b0, 32'h0, 0, "ws3 r30", r);
        check("aborted write not performed", r, 32'hA5A5_A5A5);

        // Randomized traffic against the reference image, each instance.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 16; i++) begin
                bus_access(d, 32'h100 + 32'(4 * i), MT_WORD, 1'b0, 1'b1, $urandom, 0, "rnd init", r);
            end
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(0, 9) == 0) a = 32'h1000 + 32'($urandom_range(0, 255));
                else                           a = 32'h100 + 32'($urandom_range(0, 63));
                t  = 3'($urandom_range(0, 7));
                op = int'($urandom_range(0, 2));
                bus_access(d, a, t, op != 1, op != 0, $urandom, 0, "rnd", r);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
